// File: rtl/cpu_timing_sequencer.sv
// 6502 timing front end: two-phase qualifiers, one-hot T-state, IR/prevOP and RESET/NMI/IRQ entry.
// Latency: DB_in sampled at the Tone cycle end shows on OP at Ttwo/phi1; RDY=0 freezes sequencing, phases run on.
module cpu_timing_sequencer #(
  parameter logic [7:0] RESET_OP = 8'h00,
  parameter logic [7:0] IDLE_OP  = 8'hEA
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] DB_in,
  input  logic       tLast,
  input  logic       RDY,
  input  logic       NMI_n,
  input  logic       IRQ_n,
  input  logic       statusI,
  output logic       phi1,
  output logic       phi2,
  output logic [6:0] T,
  output logic [7:0] OP,
  output logic [7:0] prevOP,
  output logic [2:0] activeInt,
  output logic       SYNC
);

  localparam logic [6:0] TONE   = 7'b0000001;
  localparam logic [6:0] TTWO   = 7'b0000010;
  localparam logic [6:0] TSEVEN = 7'b1000000;

  localparam logic [2:0] INT_RESET = 3'b100;
  localparam logic [2:0] INT_NMI   = 3'b010;
  localparam logic [2:0] INT_IRQ   = 3'b001;
  localparam logic [2:0] INT_NONE  = 3'b000;

  logic nmiSync;
  logic nmiPend;
  logic cycleEnd;
  logic nmiFall;
  logic irqPend;
  logic closeInstr;

  // The edge that ends a phi2 phase is the only one that moves the sequencer.
  assign cycleEnd   = phi2;
  assign nmiFall    = nmiSync & ~NMI_n;
  assign irqPend    = ~IRQ_n & ~statusI;
  assign closeInstr = cycleEnd & RDY & tLast & (T != TONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phi1      <= 1'b1;
      phi2      <= 1'b0;
      T         <= TONE;
      SYNC      <= 1'b1;
      OP        <= RESET_OP;
      prevOP    <= IDLE_OP;
      activeInt <= INT_RESET;
      nmiSync   <= 1'b1;
      nmiPend   <= 1'b0;
    end else begin
      phi1    <= ~phi1;
      phi2    <= ~phi2;
      nmiSync <= NMI_n;

      // A fresh falling edge wins over consumption so back-to-back NMIs are never dropped.
      if (nmiFall)
        nmiPend <= 1'b1;
      else if (closeInstr && nmiPend)
        nmiPend <= 1'b0;

      if (cycleEnd && RDY) begin
        if (T == TONE) begin
          prevOP <= OP;
          OP     <= (activeInt != INT_NONE) ? RESET_OP : DB_in;
          T      <= TTWO;
          SYNC   <= 1'b0;
        end else if (tLast) begin
          T    <= TONE;
          SYNC <= 1'b1;
          if (nmiPend)
            activeInt <= INT_NMI;
          else if (irqPend)
            activeInt <= INT_IRQ;
          else
            activeInt <= INT_NONE;
        end else if (T == TSEVEN) begin
          T    <= TONE;
          SYNC <= 1'b1;
        end else begin
          T    <= T << 1;
          SYNC <= 1'b0;
        end
      end
    end
  end

endmodule
